// File: rtl/ppa_pipe.sv
// rtl/ppa_pipe.sv - pipelined Brent-Kung parallel prefix adder/subtractor
// Pipeline registers are spread evenly over the 2*log2(WIDTH)+1 prefix levels, the last one at the outputs.
module ppa_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] add_1,
  input  logic [WIDTH-1:0] add_2,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int LG = $clog2(WIDTH);
  localparam int NL = 2 * LG + 1;
  localparam int NW = 3 * WIDTH + 2;
  localparam int VB = NW - 1;
  localparam int CB = NW - 2;

  // Node layout: {valid, carry_in, x[W], g[W], p[W]}; x is the bitwise half-sum,
  // g/p the running group generate/propagate. Level 0 carries raw A in x and B' in p.
  logic [NW-1:0] node [0:NL];
  logic          stall;

  assign stall     = node[NL][VB] & ~out_ready;
  assign in_ready  = ~stall;
  assign node[0]   = {in_valid, sub | c_in, add_1, {WIDTH{1'b0}}, sub ? ~add_2 : add_2};

  function automatic logic [NW-1:0] level_fn(input int k, input logic [NW-1:0] n);
    logic [WIDTH-1:0] x, g, p, xn, gn, pn;
    int d;
    x  = n[3*WIDTH-1:2*WIDTH];
    g  = n[2*WIDTH-1:WIDTH];
    p  = n[WIDTH-1:0];
    xn = x;
    gn = g;
    pn = p;
    d  = 1;
    if (k == 1) begin
      // Carry-in is folded into bit 0's generate so the prefix tree needs no extra column.
      xn    = x ^ p;
      gn    = x & p;
      pn    = x ^ p;
      gn[0] = (x[0] & p[0]) | ((x[0] ^ p[0]) & n[CB]);
      pn[0] = 1'b0;
    end else if (k <= LG + 1) begin
      d = 1 << (k - 2);
      for (int i = 0; i < WIDTH; i++) begin
        if ((i + 1) % (2 * d) == 0) begin
          gn[i] = g[i] | (p[i] & g[i-d]);
          pn[i] = p[i] & p[i-d];
        end
      end
    end else if (k <= 2 * LG) begin
      d = 1 << (2 * LG - k);
      for (int i = 0; i < WIDTH; i++) begin
        if ((i >= 2 * d) && ((i + 1) % (2 * d) == d)) begin
          gn[i] = g[i] | (p[i] & g[i-d]);
          pn[i] = p[i] & p[i-d];
        end
      end
    end else begin
      // Post-processing: x becomes the sum, g[0] the carry-out, p[0] the overflow flag.
      xn[0] = x[0] ^ n[CB];
      for (int i = 1; i < WIDTH; i++) begin
        xn[i] = x[i] ^ g[i-1];
      end
      gn    = '0;
      gn[0] = g[WIDTH-1];
      pn    = '0;
      pn[0] = g[WIDTH-1] ^ g[WIDTH-2];
    end
    return {n[VB], n[CB], xn, gn, pn};
  endfunction

  for (genvar k = 1; k <= NL; k++) begin : g_lvl
    localparam bit IS_REG = ((k * STAGES) / NL) != (((k - 1) * STAGES) / NL);
    logic [NW-1:0] lvl_c;

    assign lvl_c = level_fn(k, node[k-1]);

    if (IS_REG) begin : g_reg
      logic [NW-1:0] stage_d, stage_q;

      always_comb begin
        stage_d = stall ? stage_q : lvl_c;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) stage_q <= '0;
        else     stage_q <= stage_d;
      end

      assign node[k] = stage_q;
    end else begin : g_comb
      assign node[k] = lvl_c;
    end
  end

  assign out_valid = node[NL][VB];
  assign sum       = node[NL][3*WIDTH-1:2*WIDTH];
  assign c_out     = node[NL][WIDTH];
  assign ovf       = node[NL][0];

endmodule

// File: tb/tb_ppa_pipe.sv
// tb/tb_ppa_pipe.sv - scoreboard bench for ppa_pipe at (16,2) and (32,4)
// Expected results come from integer arithmetic on the operands; a monitor per DUT pops them.
module tb_ppa_pipe;

  typedef struct {
    logic [63:0] sum;
    logic        co;
    logic        ov;
  } exp_t;

  localparam int SA = 2;
  localparam int NOPS = 10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, in_valid_a, in_ready_a, cin_a, sub_a, out_valid_a, out_ready_a, co_a, ov_a;
  logic [15:0] add1_a, add2_a, sum_a;
  logic        rst_b, in_valid_b, in_ready_b, cin_b, sub_b, out_valid_b, out_ready_b, co_b, ov_b;
  logic [31:0] add1_b, add2_b, sum_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;
  bit   done_a = 1'b0;
  bit   done_b = 1'b0;

  ppa_pipe #(.WIDTH(16), .STAGES(2)) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .add_1(add1_a), .add_2(add2_a), .c_in(cin_a), .sub(sub_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .sum(sum_a), .c_out(co_a), .ovf(ov_a)
  );

  ppa_pipe #(.WIDTH(32), .STAGES(4)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .add_1(add1_b), .add_2(add2_b), .c_in(cin_b), .sub(sub_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .sum(sum_b), .c_out(co_b), .ovf(ov_b)
  );

  function automatic exp_t model(input int w, input longint unsigned a, input longint unsigned b,
                                 input logic cin, input logic s);
    longint unsigned mask, t, uhalf;
    longint          half, sa, sb, r;
    exp_t            e;
    mask  = (64'd1 << w) - 64'd1;
    uhalf = 64'd1 << (w - 1);
    half  = longint'(uhalf);
    if (s) t = a + ((~b) & mask) + 64'd1;
    else   t = a + b + {63'd0, cin};
    e.sum = t & mask;
    e.co  = ((t >> w) & 64'd1) != 64'd0;
    sa    = (a >= uhalf) ? longint'(a) - 2 * half : longint'(a);
    sb    = (b >= uhalf) ? longint'(b) - 2 * half : longint'(b);
    r     = s ? sa - sb : sa + sb + longint'({63'd0, cin});
    e.ov  = (r < -half) || (r >= half);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [63:0] pick_operand(input int w);
    logic [63:0] mask, v;
    mask = (64'd1 << w) - 64'd1;
    v    = {$urandom, $urandom};
    case ($urandom_range(7))
      0: v = 64'd0;
      1: v = mask;
      2: v = 64'd1 << (w - 1);
      3: v = (64'd1 << (w - 1)) - 64'd1;
      default: v = v & mask;
    endcase
    return v & mask;
  endfunction

  // Output monitors: compare every presented result against the queue head; pop on transfer.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_a && out_valid_a) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_result: got sum %0d with no result pending", sum_a);
      end else begin
        e = q_a[0];
        check("a_sum", {48'd0, sum_a}, e.sum);
        check("a_c_out", {63'd0, co_a}, {63'd0, e.co});
        check("a_ovf", {63'd0, ov_a}, {63'd0, e.ov});
        if (out_ready_a) void'(q_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_b && out_valid_b) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_result: got sum %0d with no result pending", sum_b);
      end else begin
        e = q_b[0];
        check("b_sum", {32'd0, sum_b}, e.sum);
        check("b_c_out", {63'd0, co_b}, {63'd0, e.co});
        check("b_ovf", {63'd0, ov_b}, {63'd0, e.ov});
        if (out_ready_b) void'(q_b.pop_front());
      end
    end
  end

  task automatic drive_a(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic s,
                         output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    in_valid_a = 1'b1;
    add1_a = a;
    add2_a = b;
    cin_a  = ci;
    sub_a  = s;
    #1;
    while (!in_ready_a && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = in_ready_a;
    if (!ok) check("a_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_model_a(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic s);
    bit ok;
    drive_a(a, b, ci, s, ok);
    if (ok) q_a.push_back(model(16, a, b, ci, s));
  endtask

  task automatic send_const_a(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic s,
                              input exp_t e);
    bit ok;
    drive_a(a, b, ci, s, ok);
    if (ok) q_a.push_back(e);
  endtask

  task automatic latency_a();
    for (int c = 1; c <= SA; c++) begin
      @(negedge clk);
      if (c == 1) in_valid_a = 1'b0;
      #1;
      check($sformatf("a_latency_cycle%0d", c), {63'd0, out_valid_a}, {63'd0, c == SA});
    end
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    @(negedge clk);
    in_valid_a = 1'b0;
    while (q_a.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("a_drained", q_a.size(), 64'd0);
  endtask

  initial begin
    bit acc;
    int n;
    rst_a = 1'b1; in_valid_a = 1'b0; out_ready_a = 1'b1;
    add1_a = '0; add2_a = '0; cin_a = 1'b0; sub_a = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("a_rst_out_valid", {63'd0, out_valid_a}, 64'd0);
    check("a_rst_in_ready", {63'd0, in_ready_a}, 64'd1);
    check("a_rst_sum", {48'd0, sum_a}, 64'd0);
    check("a_rst_c_out", {63'd0, co_a}, 64'd0);
    check("a_rst_ovf", {63'd0, ov_a}, 64'd0);
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    check("a_in_ready_after_release", {63'd0, in_ready_a}, 64'd1);

    send_const_a(16'd4322, 16'd7656, 1'b1, 1'b0, '{sum: 64'd11979, co: 1'b0, ov: 1'b0});
    latency_a();
    drain_a();

    send_const_a(16'd987, 16'd71, 1'b0, 1'b0, '{sum: 64'd1058, co: 1'b0, ov: 1'b0});
    send_const_a(16'd65534, 16'd1, 1'b0, 1'b0, '{sum: 64'd65535, co: 1'b0, ov: 1'b0});
    send_const_a(16'd65534, 16'd1, 1'b1, 1'b0, '{sum: 64'd0, co: 1'b1, ov: 1'b0});
    send_const_a(16'd1000, 16'd1001, 1'b1, 1'b1, '{sum: 64'd65535, co: 1'b0, ov: 1'b0});
    send_const_a(16'd32767, 16'd1, 1'b0, 1'b0, '{sum: 64'd32768, co: 1'b0, ov: 1'b1});
    drain_a();

    fork
      begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          out_ready_a = 1'b0;
          #1;
          check($sformatf("a_stall_in_ready_c%0d", c), {63'd0, in_ready_a}, {63'd0, c < 2});
        end
        @(negedge clk);
        out_ready_a = 1'b1;
      end
      begin
        for (int i = 0; i < 4; i++)
          send_model_a(16'(pick_operand(16)), 16'(pick_operand(16)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      end
    join
    drain_a();

    out_ready_a = 1'b0;
    send_model_a(16'd100, 16'd200, 1'b0, 1'b0);
    send_model_a(16'd300, 16'd400, 1'b0, 1'b1);
    @(negedge clk);
    in_valid_a = 1'b0;
    #1;
    rst_a = 1'b1;
    q_a.delete();
    #1;
    check("a_midrst_out_valid", {63'd0, out_valid_a}, 64'd0);
    check("a_midrst_in_ready", {63'd0, in_ready_a}, 64'd1);
    check("a_midrst_sum", {48'd0, sum_a}, 64'd0);
    @(negedge clk);
    rst_a = 1'b0;
    out_ready_a = 1'b1;
    #1;
    check("a_postrst_in_ready", {63'd0, in_ready_a}, 64'd1);
    send_const_a(16'd5, 16'd7, 1'b1, 1'b0, '{sum: 64'd13, co: 1'b0, ov: 1'b0});
    latency_a();
    drain_a();

    acc = 1'b0;
    n = 0;
    while (n < NOPS) begin
      @(negedge clk);
      if (acc) begin
        in_valid_a = 1'b0;
        acc = 1'b0;
      end
      out_ready_a = ($urandom_range(3) != 0);
      if (!in_valid_a && $urandom_range(3) != 0) begin
        in_valid_a = 1'b1;
        add1_a = 16'(pick_operand(16));
        add2_a = 16'(pick_operand(16));
        cin_a  = 1'($urandom_range(1));
        sub_a  = 1'($urandom_range(1));
      end
      #1;
      if (in_valid_a && in_ready_a) begin
        q_a.push_back(model(16, add1_a, add2_a, cin_a, sub_a));
        acc = 1'b1;
        n++;
      end
    end
    @(negedge clk);
    in_valid_a = 1'b0;
    out_ready_a = 1'b1;
    done_a = 1'b1;
  end

  initial begin
    bit acc;
    int n;
    rst_b = 1'b1; in_valid_b = 1'b0; out_ready_b = 1'b1;
    add1_b = '0; add2_b = '0; cin_b = 1'b0; sub_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    acc = 1'b0;
    n = 0;
    while (n < NOPS) begin
      @(negedge clk);
      if (acc) begin
        in_valid_b = 1'b0;
        acc = 1'b0;
      end
      out_ready_b = ($urandom_range(3) != 0);
      if (!in_valid_b && $urandom_range(3) != 0) begin
        in_valid_b = 1'b1;
        add1_b = 32'(pick_operand(32));
        add2_b = 32'(pick_operand(32));
        cin_b  = 1'($urandom_range(1));
        sub_b  = 1'($urandom_range(1));
      end
      #1;
      if (in_valid_b && in_ready_b) begin
        q_b.push_back(model(32, add1_b, add2_b, cin_b, sub_b));
        acc = 1'b1;
        n++;
      end
    end
    @(negedge clk);
    in_valid_b = 1'b0;
    out_ready_b = 1'b1;
    done_b = 1'b1;
  end

  initial begin
    int n;
    wait (done_a && done_b);
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    check("a_final_drained", q_a.size(), 64'd0);
    check("b_final_drained", q_b.size(), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: run did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
